// File: rtl/dmem_access_ctrl.sv
//------------------------------------------------------------------------------
// dmem_access_ctrl: MEM-stage load/store initiator issuing byte-enabled
// word requests over a req/ack handshake, with load lane extraction.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] exmem_alu_i,
  input  logic [31:0]       exmem_mux7_i,
  input  logic              exmem_m_MW_i,
  input  logic              exmem_m_MR_i,
  input  logic [1:0]        exmem_size_i,
  input  logic              exmem_uns_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       read_data_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              bus_err_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [1:0]        r_lane;
  logic [31:0]       r_rdata;
  logic              r_misalign;
  logic              r_berr;

  logic        w_valid, w_mis, w_start, w_timeout;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;

  assign w_valid = exmem_m_MR_i | exmem_m_MW_i;
  assign w_lane  = exmem_alu_i[1:0];
  // Size 11 is decoded as word, so only bit 1 matters for the word case.
  assign w_mis   = ((exmem_size_i == 2'b01) & w_lane[0]) |
                   (exmem_size_i[1] & (w_lane != 2'b00));
  assign w_start = (r_state == S_IDLE) & w_valid & ~w_mis;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = exmem_mux7_i;
    case (exmem_size_i)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{exmem_mux7_i[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{exmem_mux7_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_rbyte = mem_rdata_i[{r_lane, 3'b000} +: 8];
  assign w_rhalf = r_lane[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    w_load = mem_rdata_i;
    case (r_size)
      2'b00:   w_load = {{24{~r_uns & w_rbyte[7]}}, w_rbyte};
      2'b01:   w_load = {{16{~r_uns & w_rhalf[15]}}, w_rhalf};
      default: ;
    endcase
  end

  // An ack landing on the last counted cycle wins over the timeout.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_tmo_last) && !mem_ack_i;

  always_comb begin
    w_next    = r_state;
    stall_o   = 1'b0;
    mem_req_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_o = w_start;
        if (w_start) w_next = S_REQ;
      end
      S_REQ: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        if (mem_ack_i || w_timeout) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_be       <= 4'b0000;
      r_wdata    <= '0;
      r_size     <= 2'b00;
      r_uns      <= 1'b0;
      r_lane     <= 2'b00;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
      r_berr     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_misalign <= (r_state == S_IDLE) & w_valid & w_mis;
      r_berr     <= (r_state == S_REQ) & w_timeout;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_start) begin
            r_addr  <= {exmem_alu_i[ADDR_W-1:2], 2'b00};
            r_we    <= exmem_m_MW_i;
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_size  <= exmem_size_i;
            r_uns   <= exmem_uns_i;
            r_lane  <= w_lane;
          end else if (w_valid && !exmem_m_MW_i) begin
            r_rdata <= '0;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (mem_ack_i) begin
            if (!r_we) r_rdata <= w_load;
          end else if (w_timeout) begin
            r_rdata <= '0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_be_o    = r_be;
  assign mem_wdata_o = r_wdata;
  assign read_data_o = r_rdata;
  assign misalign_o  = r_misalign;
  assign bus_err_o   = r_berr;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
//------------------------------------------------------------------------------
// tb_dmem_access_ctrl: table-driven bench for dmem_access_ctrl (TIMEOUT = 4)
// with a cycle-counting memory responder and hand-written reset/ack sequences.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] exmem_alu_i = '0;
  logic [31:0] exmem_mux7_i = '0;
  logic        exmem_m_MW_i = 1'b0;
  logic        exmem_m_MR_i = 1'b0;
  logic [1:0]  exmem_size_i = 2'b00;
  logic        exmem_uns_i = 1'b0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] read_data_o;
  logic        stall_o, misalign_o, bus_err_o;

  int checks = 0;
  int failures = 0;

  dmem_access_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .exmem_alu_i(exmem_alu_i), .exmem_mux7_i(exmem_mux7_i),
    .exmem_m_MW_i(exmem_m_MW_i), .exmem_m_MR_i(exmem_m_MR_i),
    .exmem_size_i(exmem_size_i), .exmem_uns_i(exmem_uns_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .read_data_o(read_data_o), .stall_o(stall_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        mr, mw;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, data, rdata;
    int          lat;        // REQ cycle carrying the ack; 0 = never ack
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we, chk_wdata;
    logic [31:0] e_rd;
    int          e_stall, e_req;
    logic        e_mis, e_berr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_access(input int idx, input vec_t v);
    int          stall_cnt = 0, req_cyc = 0;
    bit          ended = 0, stable = 1, saw_berr = 0, last_stall;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic [3:0]  c_be = '0;
    logic        c_we = 1'b0;
    string       tag;
    tag = $sformatf("v%0d", idx);
    exmem_alu_i  = v.addr;
    exmem_mux7_i = v.data;
    exmem_m_MR_i = v.mr;
    exmem_m_MW_i = v.mw;
    exmem_size_i = v.size;
    exmem_uns_i  = v.uns;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (stall_o) stall_cnt++;
      if (bus_err_o) saw_berr = 1;
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        req_cyc++;
        if (req_cyc == 1) begin
          c_addr = mem_addr_o; c_be = mem_be_o; c_wdata = mem_wdata_o; c_we = mem_we_o;
        end else if (mem_addr_o !== c_addr || mem_be_o !== c_be ||
                     mem_wdata_o !== c_wdata || mem_we_o !== c_we) begin
          stable = 0;
        end
        if (req_cyc == v.lat) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = v.rdata;
        end
      end
      last_stall = stall_o;
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      if (!last_stall) begin
        ended = 1;
        break;
      end
    end
    exmem_m_MR_i = 1'b0;
    exmem_m_MW_i = 1'b0;
    chk({tag, "_completed_in_bound"}, 32'(ended), 32'd1);
    chk({tag, "_stall_cycles"}, stall_cnt, v.e_stall);
    chk({tag, "_req_cycles"}, req_cyc, v.e_req);
    chk({tag, "_bus_err"}, 32'(saw_berr), 32'(v.e_berr));
    if (v.e_req > 0) begin
      chk({tag, "_mem_addr"}, c_addr, v.e_addr);
      chk({tag, "_mem_be"}, 32'(c_be), 32'(v.e_be));
      chk({tag, "_mem_we"}, 32'(c_we), 32'(v.e_we));
      chk({tag, "_req_stable"}, 32'(stable), 32'd1);
      if (v.chk_wdata) chk({tag, "_mem_wdata"}, c_wdata, v.e_wdata);
    end
    @(negedge clk_i);
    chk({tag, "_misalign"}, 32'(misalign_o), 32'(v.e_mis));
    chk({tag, "_read_data"}, read_data_o, v.e_rd);
    @(negedge clk_i);
    chk({tag, "_misalign_clear"}, 32'(misalign_o), 32'd0);
    chk({tag, "_idle_no_req"}, 32'(mem_req_o), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    //           mr mw  size  uns addr          data          rdata         lat e_addr        e_be    e_wdata       we  cw  e_rd          st rq mis berr
    vecs[0]  = '{0, 1, 2'b10, 0, 32'h00000008, 32'hDEADBEEF, 32'h0,        3, 32'h00000008, 4'b1111, 32'hDEADBEEF, 1, 1, 32'h00000000, 4, 3, 0, 0};
    vecs[1]  = '{0, 1, 2'b00, 0, 32'h0000000D, 32'h000000A5, 32'h0,        1, 32'h0000000C, 4'b0010, 32'hA5A5A5A5, 1, 1, 32'h00000000, 2, 1, 0, 0};
    vecs[2]  = '{1, 0, 2'b00, 0, 32'h0000000E, 32'h0,        32'h12F03456, 2, 32'h0000000C, 4'b0100, 32'h0,        0, 0, 32'hFFFFFFF0, 3, 2, 0, 0};
    vecs[3]  = '{1, 0, 2'b00, 1, 32'h0000000E, 32'h0,        32'h12F03456, 1, 32'h0000000C, 4'b0100, 32'h0,        0, 0, 32'h000000F0, 2, 1, 0, 0};
    vecs[4]  = '{0, 1, 2'b01, 0, 32'h00000006, 32'h1234BEEF, 32'h0,        1, 32'h00000004, 4'b1100, 32'hBEEFBEEF, 1, 1, 32'h000000F0, 2, 1, 0, 0};
    vecs[5]  = '{1, 0, 2'b01, 0, 32'h00000002, 32'h0,        32'h8001FFFF, 2, 32'h00000000, 4'b1100, 32'h0,        0, 0, 32'hFFFF8001, 3, 2, 0, 0};
    vecs[6]  = '{1, 0, 2'b01, 1, 32'h00000000, 32'h0,        32'h8001FFFF, 1, 32'h00000000, 4'b0011, 32'h0,        0, 0, 32'h0000FFFF, 2, 1, 0, 0};
    vecs[7]  = '{0, 1, 2'b01, 0, 32'h00000005, 32'h00001234, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        0, 0, 32'h0000FFFF, 0, 0, 1, 0};
    vecs[8]  = '{1, 0, 2'b10, 0, 32'h00000003, 32'h0,        32'h55555555, 1, 32'h0,        4'b0000, 32'h0,        0, 0, 32'h00000000, 0, 0, 1, 0};
    vecs[9]  = '{1, 0, 2'b10, 0, 32'h00000010, 32'h0,        32'hCAFEF00D, 4, 32'h00000010, 4'b1111, 32'h0,        0, 0, 32'hCAFEF00D, 5, 4, 0, 0};
    vecs[10] = '{1, 1, 2'b11, 0, 32'h00000020, 32'h11223344, 32'h99999999, 1, 32'h00000020, 4'b1111, 32'h11223344, 1, 1, 32'hCAFEF00D, 2, 1, 0, 0};
    vecs[11] = '{1, 0, 2'b00, 0, 32'h0000001B, 32'h0,        32'h7F000000, 1, 32'h00000018, 4'b1000, 32'h0,        0, 0, 32'h0000007F, 2, 1, 0, 0};
    vecs[12] = '{1, 0, 2'b10, 0, 32'h00000030, 32'h0,        32'h0,        0, 32'h00000030, 4'b1111, 32'h0,        0, 0, 32'h00000000, 5, 4, 0, 1};
    vecs[13] = '{1, 0, 2'b10, 0, 32'h00000044, 32'h0,        32'h0BADF00D, 2, 32'h00000044, 4'b1111, 32'h0,        0, 0, 32'h0BADF00D, 3, 2, 0, 0};

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_be", 32'(mem_be_o), 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_read_data", read_data_o, 32'd0);
    chk("rst_flags", {29'd0, stall_o, misalign_o, bus_err_o}, 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 13; i++) do_access(i, vecs[i]);

    // Reset asserted while a load sits in REQ must drop the request at once.
    exmem_alu_i  = 32'h00000040;
    exmem_size_i = 2'b10;
    exmem_uns_i  = 1'b0;
    exmem_m_MR_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rstmid_req_before", 32'(mem_req_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("rstmid_req_dropped", 32'(mem_req_o), 32'd0);
    chk("rstmid_addr_cleared", mem_addr_o, 32'd0);
    exmem_m_MR_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    chk("rstmid_idle_stall", 32'(stall_o), 32'd0);
    chk("rstmid_idle_req", 32'(mem_req_o), 32'd0);
    @(posedge clk_i);
    #1;
    do_access(13, vecs[13]);

    // A stray ack while idle must not touch the load result.
    @(negedge clk_i);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFFFFFF;
    @(posedge clk_i);
    #1 mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("stray_ack_read_data", read_data_o, 32'h0BADF00D);
    chk("stray_ack_no_req", 32'(mem_req_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
